ram_bank_ctrl: RTL and testbench
================================

// Module: ram_bank_ctrl
// PURPOSE
//  Parametrised successor to the 2-bank write-enable decoder: routes processor port
//  writes/reads to NUM_BANKS RAM banks via an internal bank-select register at port
//  BANK_PORT_ID. Pipelines read-data return to match RAM read latency.
//  Sits between processor I/O port bus and the bank RAMs.
// PARAMETERS
//  NUM_BANKS    4      number of RAM banks (2..16)
//  BANK_W       2      bank index width, = clog2(NUM_BANKS)
//  DATA_W       8      port data width
//  ADDR_W       8      port_id width
//  BANK_PORT_ID 8'hFF  port address of bank-select/status register
//  RD_LAT       1      RAM read latency in cycles (1..4)
// PORTS
//  clk          in   1                 clock, rising edge
//  rst_n        in   1                 async reset, active low
//  port_id      in   ADDR_W            processor port address
//  out_port     in   DATA_W            processor write data
//  write_strobe in   1                 1-cycle write pulse
//  read_strobe  in   1                 1-cycle read pulse
//  bank_we      out  NUM_BANKS         per-bank write enable (one-hot or zero)
//  bank_re      out  NUM_BANKS         per-bank read enable (one-hot or zero)
//  bank_rdata   in   NUM_BANKS*DATA_W  bank read data, bank k at [k*DATA_W +: DATA_W]
//  in_port      out  DATA_W            read data to processor
//  rd_valid     out  1                 in_port valid pulse
//  bank_sel     out  BANK_W            current bank register
//  sel_err      out  1                 sticky: out-of-range bank write seen
// BEHAVIOUR
//  Reset (async, rst_n=0): bank_sel=0, sel_err=0, in_port=0, rd_valid=0, read pipe
//   cleared; bank_we/bank_re=0 while in reset.
//  Bank write: write_strobe & port_id==BANK_PORT_ID: v=out_port[BANK_W-1:0];
//   out_port[DATA_W-1:BANK_W]==0 and v<NUM_BANKS -> bank_sel<=v, sel_err<=0 next edge;
//   otherwise bank_sel unchanged, sel_err<=1. No bank_we asserted for this access.
//  Data write: write_strobe & port_id!=BANK_PORT_ID -> bank_we[bank_sel]=1 same cycle
//   (combinational from registered bank_sel); all others 0.
//  Data read: read_strobe & port_id!=BANK_PORT_ID -> bank_re[bank_sel]=1 same cycle;
//   bank index captured into RD_LAT-deep shift pipe with valid bit.
//   After RD_LAT edges, in_port<=bank_rdata slice of captured index, rd_valid=1 for
//   one cycle. Total latency strobe->rd_valid = RD_LAT+1 cycles.
//  Status read: read_strobe & port_id==BANK_PORT_ID -> no bank_re; status word
//   {sel_err, zeros, bank_sel} enters same pipe, returned with identical latency.
//  Back-to-back reads every cycle accepted; pipe holds RD_LAT in flight, results in
//   order, one rd_valid per strobe.
//  Bank change while reads in flight: in-flight reads use bank captured at strobe.
//  Bank write and data write same cycle impossible (single port_id); write_strobe
//   and read_strobe same cycle: both performed independently; a bank write in that
//   cycle affects only subsequent accesses.
//  Reset mid-read: pipe flushed, no rd_valid issued for pending reads.
//  in_port holds last value when rd_valid=0.
// TESTING
//  Reset, write 8'h02 to port FF, write port 10 -> bank_we=4'b0100 that cycle only.
//  Write 8'h05 to FF (NUM_BANKS=4) -> bank_sel stays 2, sel_err=1; write 8'h01 ->
//   bank_sel=1, sel_err=0.
//  RD_LAT=2: bank 3 rdata=8'hA5, read_strobe port 20 -> bank_re=4'b1000, rd_valid +
//   in_port=A5 exactly 3 cycles later.
//  Read bank 0, switch to bank 1 next cycle, read again -> two rd_valid pulses in
//   order with bank0 then bank1 data.
//  Read port FF after bad write -> in_port=8'h80|bank_sel.
//  Assert rst_n low with 2 reads pending -> no rd_valid, all outputs at reset values.

Source files
------------

// File: rtl/ram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_bank_ctrl
// Purpose  : Routes port-bus accesses to NUM_BANKS RAM banks via a bank-select
//            register, and returns read data pipelined to the RAM read latency.
// Revision : 1.0
// ============================================================================
module ram_bank_ctrl #(
  parameter int                NUM_BANKS    = 4,
  parameter int                BANK_W       = 2,
  parameter int                DATA_W       = 8,
  parameter int                ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] BANK_PORT_ID = 8'hFF,
  parameter int                RD_LAT       = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           port_id,
  input  logic [DATA_W-1:0]           out_port,
  input  logic                        write_strobe,
  input  logic                        read_strobe,
  output logic [NUM_BANKS-1:0]        bank_we,
  output logic [NUM_BANKS-1:0]        bank_re,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
  output logic [DATA_W-1:0]           in_port,
  output logic                        rd_valid,
  output logic [BANK_W-1:0]           bank_sel,
  output logic                        sel_err
);

  localparam logic [BANK_W:0] c_num_banks = NUM_BANKS[BANK_W:0];

  logic [BANK_W-1:0] r_bank_sel;
  logic              r_sel_err;
  logic [DATA_W-1:0] r_in_port;
  logic              r_rd_valid;

  // Read pipe: per stage a valid bit, a status flag, the captured bank and
  // the status word snapshot (used only for status reads).
  logic [RD_LAT-1:0] r_pv;
  logic [RD_LAT-1:0] r_pstat;
  logic [BANK_W-1:0] r_pbank   [RD_LAT];
  logic [DATA_W-1:0] r_pstatus [RD_LAT];

  logic              w_is_bank_port;
  logic              w_bank_wr;
  logic              w_data_wr;
  logic              w_data_rd;
  logic [BANK_W-1:0] w_sel_val;
  logic              w_sel_ok;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rd_mux;
  logic [DATA_W-1:0] w_ret;

  assign w_is_bank_port = (port_id == BANK_PORT_ID);
  assign w_bank_wr      = write_strobe & w_is_bank_port;
  assign w_data_wr      = write_strobe & ~w_is_bank_port;
  assign w_data_rd      = read_strobe & ~w_is_bank_port;
  assign w_sel_val      = out_port[BANK_W-1:0];
  assign w_sel_ok       = (out_port[DATA_W-1:BANK_W] == '0) &&
                          ({1'b0, w_sel_val} < c_num_banks);

  always_comb begin
    w_status              = '0;
    w_status[DATA_W-1]    = r_sel_err;
    w_status[BANK_W-1:0]  = r_bank_sel;
  end

  // Enables are forced low while reset is asserted.
  always_comb begin
    bank_we = '0;
    bank_re = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      bank_we[k] = rst_n & w_data_wr & (r_bank_sel == BANK_W'(k));
      bank_re[k] = rst_n & w_data_rd & (r_bank_sel == BANK_W'(k));
    end
  end

  always_comb begin
    w_rd_mux = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (r_pbank[RD_LAT-1] == BANK_W'(k)) begin
        w_rd_mux = bank_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_ret = r_pstat[RD_LAT-1] ? r_pstatus[RD_LAT-1] : w_rd_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_sel <= '0;
      r_sel_err  <= 1'b0;
      r_in_port  <= '0;
      r_rd_valid <= 1'b0;
      r_pv       <= '0;
      r_pstat    <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pbank[i]   <= '0;
        r_pstatus[i] <= '0;
      end
    end else begin
      if (w_bank_wr) begin
        if (w_sel_ok) begin
          r_bank_sel <= w_sel_val;
          r_sel_err  <= 1'b0;
        end else begin
          r_sel_err  <= 1'b1;
        end
      end

      r_pv[0]      <= read_strobe;
      r_pstat[0]   <= w_is_bank_port;
      r_pbank[0]   <= r_bank_sel;
      r_pstatus[0] <= w_status;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]      <= r_pv[i-1];
        r_pstat[i]   <= r_pstat[i-1];
        r_pbank[i]   <= r_pbank[i-1];
        r_pstatus[i] <= r_pstatus[i-1];
      end

      r_rd_valid <= r_pv[RD_LAT-1];
      if (r_pv[RD_LAT-1]) begin
        r_in_port <= w_ret;
      end
    end
  end

  assign bank_sel = r_bank_sel;
  assign sel_err  = r_sel_err;
  assign in_port  = r_in_port;
  assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_ram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_bank_ctrl
// Purpose  : Scoreboard bench for ram_bank_ctrl with banked RAM model.
// Revision : 1.0
// ============================================================================
module tb_ram_bank_ctrl;
  localparam int NB  = 4;
  localparam int BW  = 2;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [AW-1:0]  port_id;
  logic [DW-1:0]  out_port;
  logic           write_strobe;
  logic           read_strobe;
  logic [NB-1:0]  bank_we;
  logic [NB-1:0]  bank_re;
  logic [NB*DW-1:0] bank_rdata;
  logic [DW-1:0]  in_port;
  logic           rd_valid;
  logic [BW-1:0]  bank_sel;
  logic           sel_err;

  ram_bank_ctrl #(
    .NUM_BANKS(NB), .BANK_W(BW), .DATA_W(DW), .ADDR_W(AW),
    .BANK_PORT_ID(8'hFF), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe),
    .bank_we(bank_we), .bank_re(bank_re), .bank_rdata(bank_rdata),
    .in_port(in_port), .rd_valid(rd_valid), .bank_sel(bank_sel), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] last_in = 8'h00;

  // Reference model state
  logic [7:0] ref_mem [NB][256];
  int         msel;
  int         merr;

  // Bank RAM environment, driven only by the DUT's enables
  logic [7:0] ram   [NB][256];
  logic [7:0] rpipe [NB][LAT];
  logic       ram_init = 1'b1;

  function automatic logic [7:0] finit(int k, int a);
    return 8'(k * 37 + a * 11 + 5);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (ram_init) begin
        for (int a = 0; a < 256; a++) ram[k][a] <= finit(k, a);
      end else if (bank_we[k]) begin
        ram[k][port_id] <= out_port;
      end
      rpipe[k][0] <= ram[k][port_id];
      for (int i = 1; i < LAT; i++) rpipe[k][i] <= rpipe[k][i-1];
    end
  end

  always_comb begin
    bank_rdata = '0;
    for (int k = 0; k < NB; k++) bank_rdata[k*DW +: DW] = rpipe[k][LAT-1];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every rd_valid pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      last_in = 8'h00;
      chk("rd_valid_in_reset", {31'd0, rd_valid}, 32'd0);
    end else if (rd_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got in_port %0h with no read pending", in_port);
      end else begin
        mon_e = sbq.pop_front();
        chk("rd_data", {24'd0, in_port}, {24'd0, mon_e.data});
        chk("rd_latency", cyc, mon_e.due);
        last_in = mon_e.data;
      end
    end else begin
      chk("in_port_hold", {24'd0, in_port}, {24'd0, last_in});
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        chk("rd_timeout", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic step(bit wr, bit rd, logic [7:0] pid, logic [7:0] d);
    logic [3:0] we_e;
    logic [3:0] re_e;
    logic [7:0] rv;
    write_strobe = wr;
    read_strobe  = rd;
    port_id      = pid;
    out_port     = d;
    #1;
    chk("bank_sel", {30'd0, bank_sel}, msel);
    chk("sel_err", {31'd0, sel_err}, merr);
    we_e = (wr && pid != 8'hFF) ? 4'(1 << msel) : 4'd0;
    re_e = (rd && pid != 8'hFF) ? 4'(1 << msel) : 4'd0;
    chk("bank_we", {28'd0, bank_we}, {28'd0, we_e});
    chk("bank_re", {28'd0, bank_re}, {28'd0, re_e});
    if (rd) begin
      rv = (pid == 8'hFF) ? 8'((merr << 7) | msel) : ref_mem[msel][pid];
      sbq.push_back('{data: rv, due: cyc + LAT + 1});
    end
    if (wr) begin
      if (pid == 8'hFF) begin
        if (int'(d) < NB) begin
          msel = int'(d);
          merr = 0;
        end else begin
          merr = 1;
        end
      end else begin
        ref_mem[msel][pid] = d;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic check_reset_outputs();
    chk("rst_bank_we", {28'd0, bank_we}, 32'd0);
    chk("rst_bank_re", {28'd0, bank_re}, 32'd0);
    chk("rst_bank_sel", {30'd0, bank_sel}, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
    chk("rst_in_port", {24'd0, in_port}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    logic       wr;
    logic       rd;
    logic [7:0] pid;
    logic [7:0] d;
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    port_id      = 8'h00;
    out_port     = 8'h00;
    msel = 0;
    merr = 0;
    for (int k = 0; k < NB; k++)
      for (int a = 0; a < 256; a++) ref_mem[k][a] = finit(k, a);

    @(posedge clk);
    #1;
    ram_init = 1'b0;
    write_strobe = 1'b1;
    read_strobe  = 1'b1;
    port_id      = 8'h10;
    #1;
    check_reset_outputs();
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Bank select then data write
    step(1'b1, 1'b0, 8'hFF, 8'h02);
    step(1'b1, 1'b0, 8'h10, 8'h5A);
    idle(1);
    // Out-of-range then valid select
    step(1'b1, 1'b0, 8'hFF, 8'h05);
    step(1'b1, 1'b0, 8'hFF, 8'h01);
    idle(1);
    // Bank 3 read of A5
    step(1'b1, 1'b0, 8'hFF, 8'h03);
    step(1'b1, 1'b0, 8'h20, 8'hA5);
    step(1'b0, 1'b1, 8'h20, 8'h00);
    idle(4);
    // Reads across a bank switch
    step(1'b1, 1'b0, 8'hFF, 8'h00);
    step(1'b0, 1'b1, 8'h05, 8'h00);
    step(1'b1, 1'b0, 8'hFF, 8'h01);
    step(1'b0, 1'b1, 8'h05, 8'h00);
    idle(4);
    // Status read after a bad select
    step(1'b1, 1'b0, 8'hFF, 8'h09);
    step(1'b0, 1'b1, 8'hFF, 8'h00);
    idle(4);
    // Reset with two reads in flight
    step(1'b0, 1'b1, 8'h03, 8'h00);
    step(1'b0, 1'b1, 8'h04, 8'h00);
    rst_n = 1'b0;
    sbq.delete();
    msel = 0;
    merr = 0;
    #1;
    check_reset_outputs();
    idle(3);
    rst_n = 1'b1;
    idle(4);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      wr  = ($urandom % 3) == 0;
      rd  = ($urandom % 2) == 0;
      pid = (($urandom % 5) == 0) ? 8'hFF : 8'($urandom % 16);
      if (pid == 8'hFF)
        d = (($urandom % 4) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom % 4);
      else
        d = 8'($urandom % 256);
      step(wr, rd, pid, d);
    end

    idle(8);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
